// File: rtl/ldo_rail_monitor.sv
// rtl/ldo_rail_monitor.sv - LDO enable responder: per-rail soft-start/stop models, power-good and sequencing fault checker
//
// Purpose: models the IO, analog and logic LDO rails as ramp FSMs driven by
// the sequencer enables. It reports per-rail power-good and latches a sticky
// first-fault code when the power-up or power-down order is broken.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   io_en      - IO LDO enable
//   analog_en  - analog LDO enable
//   logic_en   - logic LDO enable
//   ready      - Ready indication from the sequencer
//   fault_clr  - synchronous clear of the sticky fault
//   io_pg      - IO rail power-good
//   analog_pg  - analog rail power-good
//   logic_pg   - logic rail power-good
//   all_good   - all three rails good
//   fault      - sticky sequencing fault
//   fault_code - first fault code since clear/reset (0 = none)

module ldo_rail_monitor #(
   parameter int RAMP_UP_CYCLES   = 16,
   parameter int RAMP_DOWN_CYCLES = 8,
   parameter int CNT_W            = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       io_en,
   input  logic       analog_en,
   input  logic       logic_en,
   input  logic       ready,
   input  logic       fault_clr,
   output logic       io_pg,
   output logic       analog_pg,
   output logic       logic_pg,
   output logic       all_good,
   output logic       fault,
   output logic [2:0] fault_code
);

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      RAMP_UP   = 2'd1,
      GOOD      = 2'd2,
      RAMP_DOWN = 2'd3
   } rail_state_e;

   localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(RAMP_UP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOWN_LAST = CNT_W'(RAMP_DOWN_CYCLES - 1);

   // Rail index: 0 = IO, 1 = analog, 2 = logic
   rail_state_e      st_q  [3];
   rail_state_e      st_d  [3];
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [2:0]       en;
   logic [2:0]       pg_q, pg_d;
   logic             all_good_q, all_good_d;
   logic             fault_q, fault_d;
   logic [2:0]       fault_code_q, fault_code_d;
   logic [4:0]       chk;         // chk[k] fires fault code k+1
   logic [2:0]       first_code;

   always_comb begin
      en = {logic_en, analog_en, io_en};
      for (int i = 0; i < 3; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         case (st_q[i])
            OFF: begin
               if (en[i]) begin
                  st_d[i]  = RAMP_UP;
                  cnt_d[i] = '0;
               end
            end
            RAMP_UP: begin
               if (!en[i]) begin
                  st_d[i]  = RAMP_DOWN;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == UP_LAST) begin
                  st_d[i]  = GOOD;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            GOOD: begin
               if (!en[i]) begin
                  st_d[i]  = RAMP_DOWN;
                  cnt_d[i] = '0;
               end
            end
            RAMP_DOWN: begin
               if (en[i]) begin
                  st_d[i]  = RAMP_UP;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == DOWN_LAST) begin
                  st_d[i]  = OFF;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               st_d[i]  = OFF;
               cnt_d[i] = '0;
            end
         endcase
         // pg is registered from the next state so it moves on the same edge as the rail
         pg_d[i] = (st_d[i] == GOOD);
      end
      all_good_d = &pg_d;
   end

   // Order checks look at the registered rail states and the live inputs
   always_comb begin
      chk[0] = (st_q[1] == OFF) && analog_en && (st_q[0] != GOOD);
      chk[1] = (st_q[2] == OFF) && logic_en && (st_q[1] != GOOD);
      chk[2] = ready && ((st_q[0] == OFF) || (st_q[0] == RAMP_DOWN) ||
                         (st_q[1] == OFF) || (st_q[1] == RAMP_DOWN) ||
                         (st_q[2] == OFF) || (st_q[2] == RAMP_DOWN));
      chk[3] = (st_q[0] == GOOD) && !io_en && (st_q[1] != OFF);
      chk[4] = (st_q[1] == GOOD) && !analog_en && (st_q[2] != OFF);

      // Scan high to low so the lowest firing code is the one left behind
      first_code = 3'd0;
      for (int k = 4; k >= 0; k--) begin
         if (chk[k]) first_code = 3'(k + 1);
      end

      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      // A firing check beats fault_clr in the same cycle
      if (!fault_q || fault_clr) begin
         if (|chk) begin
            fault_d      = 1'b1;
            fault_code_d = first_code;
         end else if (fault_clr) begin
            fault_d      = 1'b0;
            fault_code_d = 3'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            st_q[i]  <= OFF;
            cnt_q[i] <= '0;
         end
         pg_q         <= '0;
         all_good_q   <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= 3'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         pg_q         <= pg_d;
         all_good_q   <= all_good_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign io_pg      = pg_q[0];
   assign analog_pg  = pg_q[1];
   assign logic_pg   = pg_q[2];
   assign all_good   = all_good_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_ldo_rail_monitor.sv
// tb/tb_ldo_rail_monitor.sv - directed vector bench for ldo_rail_monitor

module tb_ldo_rail_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic       io_en, analog_en, logic_en, ready, fault_clr;
   logic       io_pg, analog_pg, logic_pg, all_good, fault;
   logic [2:0] fault_code;

   int n_checks = 0;
   int n_fail   = 0;

   ldo_rail_monitor #(
      .RAMP_UP_CYCLES   (16),
      .RAMP_DOWN_CYCLES (8),
      .CNT_W            (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .io_en      (io_en),
      .analog_en  (analog_en),
      .logic_en   (logic_en),
      .ready      (ready),
      .fault_clr  (fault_clr),
      .io_pg      (io_pg),
      .analog_pg  (analog_pg),
      .logic_pg   (logic_pg),
      .all_good   (all_good),
      .fault      (fault),
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   // in  = {reset, io_en, analog_en, logic_en, ready, fault_clr}
   // exp = {io_pg, analog_pg, logic_pg, all_good, fault, fault_code[2:0]}
   typedef struct {
      logic [5:0] in;
      int         n;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [5:0] in, input int n, input logic [7:0] exp);
      vec_t v;
      v.in  = in;
      v.n   = n;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] exp);
      logic [7:0] act;
      act = {io_pg, analog_pg, logic_pg, all_good, fault, fault_code};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got pg/ag/fault/code=%b expected %b", name, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      {io_en, analog_en, logic_en, ready, fault_clr} = '0;

      // Legal power-up with the boundary edge on each rail, then ready
      add(6'b100000,  2, 8'h00);
      add(6'b010000,  1, 8'h00);
      add(6'b010000, 15, 8'h00);
      add(6'b010000,  1, 8'h80);
      add(6'b011000, 16, 8'h80);
      add(6'b011000,  1, 8'hC0);
      add(6'b011100, 16, 8'hC0);
      add(6'b011100,  1, 8'hF0);
      add(6'b011110,  3, 8'hF0);
      // Legal reverse shutdown; IO drops on the exact edge analog reaches OFF
      add(6'b011000,  1, 8'hC0);
      add(6'b011000,  7, 8'hC0);
      add(6'b011000,  1, 8'hC0);
      add(6'b010000,  1, 8'h80);
      add(6'b010000,  8, 8'h80);
      add(6'b000000,  1, 8'h00);
      add(6'b000000,  8, 8'h00);
      // Abort IO ramp at cnt=5, re-raise during RAMP_DOWN: ramp restarts from 0
      add(6'b010000,  6, 8'h00);
      add(6'b000000,  1, 8'h00);
      add(6'b000000,  3, 8'h00);
      add(6'b010000,  1, 8'h00);
      add(6'b010000, 15, 8'h00);
      add(6'b010000,  1, 8'h80);
      // Analog enabled while IO ramping at cnt=5: code 1, analog keeps ramping
      add(6'b100000,  1, 8'h00);
      add(6'b010000,  6, 8'h00);
      add(6'b011000,  1, 8'h09);
      add(6'b011000,  9, 8'h09);
      add(6'b011000,  1, 8'h89);
      add(6'b011000,  5, 8'h89);
      add(6'b011000,  1, 8'hC9);
      // Codes 2 and 3 on one edge, sticky code, set beats clear, plain clear
      add(6'b100000,  1, 8'h00);
      add(6'b000110,  1, 8'h0A);
      add(6'b000110,  2, 8'h0A);
      add(6'b000111,  1, 8'h0B);
      add(6'b000101,  1, 8'h00);
      add(6'b000100,  1, 8'h00);
      // Full power-up then IO dropped with analog GOOD: code 4; then code 5 over clear
      add(6'b100000,  1, 8'h00);
      add(6'b010000, 17, 8'h80);
      add(6'b011000, 17, 8'hC0);
      add(6'b011100, 17, 8'hF0);
      add(6'b001100,  1, 8'h6C);
      add(6'b001100,  3, 8'h6C);
      add(6'b000101,  1, 8'h2D);

      for (int i = 0; i < vecs.size(); i++) begin
         {reset, io_en, analog_en, logic_en, ready, fault_clr} = vecs[i].in;
         repeat (vecs[i].n) @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Analog back into RAMP_UP with logic GOOD and fault held at code 5
      {reset, io_en, analog_en, logic_en, ready, fault_clr} = 6'b000100 | 6'b001000;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset", 8'h2D);

      // Reset between edges must clear outputs without waiting for a clock
      #3;
      reset = 1'b1;
      #1;
      check("async_reset", 8'h00);

      // Release mid-cycle; IO ramp must restart from cnt=0
      #2;
      {reset, io_en, analog_en, logic_en, ready, fault_clr} = 6'b010000;
      repeat (16) @(posedge clk);
      #1;
      check("restart_edge15", 8'h00);
      @(posedge clk);
      #1;
      check("restart_edge16", 8'h80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ldo_rail_monitor.md
Name: ldo_rail_monitor

Overview:
- Responder side of the PMIC sequencer's LDO enable interface.
- Consumes the IO, analog and logic LDO enables plus Ready, and models each rail's soft-start and soft-stop with per-rail ramp counters.
- Returns per-rail power-good and checks sequencing order, latching a sticky fault with a first-fault code.
- Sits between the sequencer FSM and the rail outputs/LEDs; also serves as a bench checker for the sequencer.

Parameters:
RAMP_UP_CYCLES, 16, cycles spent in RAMP_UP before a rail reports good (legal range 2..2^CNT_W-1)
RAMP_DOWN_CYCLES, 8, cycles spent in RAMP_DOWN before a rail reports off (legal range 2..2^CNT_W-1)
CNT_W, 8, width of each rail ramp counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
io_en  input  1  IO LDO enable from sequencer
analog_en  input  1  analog LDO enable from sequencer
logic_en  input  1  logic LDO enable from sequencer
ready  input  1  Ready indication from sequencer
fault_clr  input  1  synchronous clear of the sticky fault
io_pg  output  1  IO rail power-good
analog_pg  output  1  analog rail power-good
logic_pg  output  1  logic rail power-good
all_good  output  1  io_pg & analog_pg & logic_pg, registered with the rail states
fault  output  1  sticky sequencing fault
fault_code  output  3  code of the first fault since last clear or reset; 0 = none

Behaviour:
- Reset (async, active-high): all rails OFF, counters 0, all outputs 0. Takes effect immediately, including mid-ramp; the first rising edge after deassertion samples inputs normally.
- Three identical rail FSMs (IO, analog, logic), each with a CNT_W counter. States: OFF, RAMP_UP, GOOD, RAMP_DOWN. The pg output is 1 only in GOOD.
- OFF: en=1 -> RAMP_UP, cnt=0.
- RAMP_UP: en=0 -> RAMP_DOWN, cnt=0. Else if cnt==RAMP_UP_CYCLES-1 -> GOOD. Else cnt+1.
- GOOD: en=0 -> RAMP_DOWN, cnt=0.
- RAMP_DOWN: en=1 -> RAMP_UP, cnt=0. Else if cnt==RAMP_DOWN_CYCLES-1 -> OFF. Else cnt+1.
- Latency: with en held high from the edge that moves OFF->RAMP_UP (edge 0), pg is 1 after edge RAMP_UP_CYCLES. With en held low from the edge that enters RAMP_DOWN, OFF is reached RAMP_DOWN_CYCLES edges later. pg drops on the edge that leaves GOOD.
- The counter never wraps; it only increments in the ramp states and reloads 0 on every state entry.
- Fault checks are evaluated each edge on the current registered rail states and the current inputs:
  - code 1: analog rail moves OFF->RAMP_UP while IO rail not GOOD.
  - code 2: logic rail moves OFF->RAMP_UP while analog rail not GOOD.
  - code 3: ready=1 while any rail is OFF or RAMP_DOWN.
  - code 4: IO rail leaves GOOD while analog rail not OFF.
  - code 5: analog rail leaves GOOD while logic rail not OFF.
- Fault latching:
  - When fault=0 and one or more checks fire: fault<=1 and fault_code<=lowest firing code.
  - While fault=1, further checks do not change fault_code.
  - fault_clr=1 clears fault and fault_code to 0, unless a check fires in the same cycle; then fault=1 and fault_code=that check's code (set wins over clear).
- Rail FSMs keep running regardless of fault; the monitor never gates enables.

Test Plan:
1. Legal power-up, defaults: io_en=1 at edge 0 -> io_pg=1 after edge 16. Then analog_en=1 -> analog_pg 16 edges later. Then logic_en=1 -> logic_pg 16 edges later and all_good=1. Then ready=1 -> fault stays 0.
2. analog_en=1 while IO rail is in RAMP_UP at cnt=5 -> fault=1, fault_code=1 on that edge. The analog rail still ramps and analog_pg rises 16 edges later.
3. io_en dropped at RAMP_UP cnt=5 -> RAMP_DOWN, io_pg never asserts, OFF 8 edges later. Re-raise io_en during RAMP_DOWN -> RAMP_UP with cnt=0.
4. Same edge: logic rail leaves OFF with analog not GOOD and ready=1 with rails off -> fault_code=2 (lowest wins). A later code-3 condition leaves code at 2. fault_clr=1 with no check firing -> fault=0, code=0. fault_clr=1 together with ready=1 and IO rail OFF -> fault=1, code=3.
5. All rails GOOD, then io_en=0 with analog still GOOD -> fault_code=4. Legal reverse shutdown (logic, then analog after logic OFF, then IO) -> no fault.
6. Assert reset asynchronously mid-RAMP_UP (between edges) -> pg, all_good, fault and fault_code all 0 immediately. After release, io_en=1 restarts the ramp from cnt=0.
